arm_mem_arb: RTL and testbench

- Arbiter and sequencer that lets the arm6 core share one single-port synchronous SRAM between instruction fetch (rom_* port) and data access (ram_* port).
- Stalls the core through cpu_en while it serialises the requests of one core cycle.
- Returns registered read data and abort flags.
- Sits between the core and the SRAM macro in the core's top level.

---
 rtl/arm_mem_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_arm_mem_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arm_mem_arb: serialises arm6 fetch and data requests onto one sync SRAM.  |
// | Optional macro ARB_FETCH_FIRST_EN services the fetch before the data.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module arm_mem_arb #(
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [31:0]       rom_addr,
    input  logic              ram_cen,
    input  logic              ram_wen,
    input  logic [3:0]        ram_flag,
    input  logic [31:0]       ram_addr,
    input  logic [31:0]       ram_wdata,
    output logic              cpu_en,
    output logic [31:0]       rom_data,
    output logic              rom_abort,
    output logic [31:0]       ram_rdata,
    output logic              ram_abort,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DACC = 3'd1;
    localparam logic [2:0] S_FACC = 3'd2;
    localparam logic [2:0] S_LAST = 3'd3;
    localparam logic [2:0] S_GO   = 3'd4;

    logic [2:0]  state, state_nxt;

    logic        lat_f_req;
    logic [31:0] lat_f_addr;
    logic        lat_d_req;
    logic        lat_d_wen;
    logic [3:0]  lat_d_flag;
    logic [31:0] lat_d_addr;
    logic [31:0] lat_d_wdata;

    logic        f_req, d_req, d_wen;
    logic [3:0]  d_flag;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        f_oor, d_oor;
    logic        cap_rom, cap_ram;

    logic              cpu_en_nxt;
    logic [31:0]       rom_data_nxt;
    logic              rom_abort_nxt;
    logic [31:0]       ram_rdata_nxt;
    logic              ram_abort_nxt;
    logic              mem_cen_nxt;
    logic              mem_wen_nxt;
    logic [3:0]        mem_be_nxt;
    logic [MEM_AW-1:0] mem_addr_nxt;
    logic [31:0]       mem_wdata_nxt;

    // In IDLE the first slot is prepared straight from the core inputs; every
    // later slot works from the copy latched at the end of IDLE.
    always_comb begin
        if (state == S_IDLE) begin
            f_req   = rom_en;
            f_addr  = rom_addr;
            d_req   = ~ram_cen;
            d_wen   = ram_wen;
            d_flag  = ram_flag;
            d_addr  = ram_addr;
            d_wdata = ram_wdata;
        end else begin
            f_req   = lat_f_req;
            f_addr  = lat_f_addr;
            d_req   = lat_d_req;
            d_wen   = lat_d_wen;
            d_flag  = lat_d_flag;
            d_addr  = lat_d_addr;
            d_wdata = lat_d_wdata;
        end
    end

    assign f_oor = (f_addr >> (MEM_AW + 2)) != 32'd0;
    assign d_oor = (d_addr >> (MEM_AW + 2)) != 32'd0;

    // Capture happens in the slot after an issue, when the SRAM data is valid.
`ifdef ARB_FETCH_FIRST_EN
    assign cap_rom = ((state == S_DACC) && f_req) || ((state == S_LAST) && f_req && !d_req);
    assign cap_ram = (state == S_LAST) && d_req;
`else
    assign cap_ram = ((state == S_FACC) && d_req) || ((state == S_LAST) && d_req && !f_req);
    assign cap_rom = (state == S_LAST) && f_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
`ifdef ARB_FETCH_FIRST_EN
            S_IDLE:  state_nxt = f_req ? S_FACC : (d_req ? S_DACC : S_GO);
            S_FACC:  state_nxt = d_req ? S_DACC : S_LAST;
            S_DACC:  state_nxt = S_LAST;
`else
            S_IDLE:  state_nxt = d_req ? S_DACC : (f_req ? S_FACC : S_GO);
            S_DACC:  state_nxt = f_req ? S_FACC : S_LAST;
            S_FACC:  state_nxt = S_LAST;
`endif
            S_LAST:  state_nxt = S_GO;
            S_GO:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values are computed for the state being entered and registered.
    always_comb begin
        cpu_en_nxt    = 1'b0;
        mem_cen_nxt   = 1'b1;
        mem_wen_nxt   = 1'b1;
        mem_be_nxt    = 4'h0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rom_data_nxt  = rom_data;
        rom_abort_nxt = rom_abort;
        ram_rdata_nxt = ram_rdata;
        ram_abort_nxt = ram_abort;
        case (state_nxt)
            S_DACC: begin
                if (!d_oor) begin
                    mem_cen_nxt  = 1'b0;
                    mem_wen_nxt  = d_wen;
                    mem_addr_nxt = d_addr[MEM_AW+1:2];
                    if (d_wen) begin
                        mem_be_nxt = 4'hF;
                    end else begin
                        mem_be_nxt    = d_flag;
                        mem_wdata_nxt = d_wdata;
                    end
                end
            end
            S_FACC: begin
                if (!f_oor) begin
                    mem_cen_nxt  = 1'b0;
                    mem_be_nxt   = 4'hF;
                    mem_addr_nxt = f_addr[MEM_AW+1:2];
                end
            end
            S_GO:    cpu_en_nxt = 1'b1;
            default: ;
        endcase
        if (state == S_IDLE) begin
            if (f_req) rom_abort_nxt = 1'b0;
            if (d_req) ram_abort_nxt = 1'b0;
        end
        if (cap_rom) begin
            rom_abort_nxt = f_oor;
            rom_data_nxt  = f_oor ? 32'd0 : mem_rdata;
        end
        if (cap_ram) begin
            ram_abort_nxt = d_oor;
            if (d_wen) ram_rdata_nxt = d_oor ? 32'd0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_en    <= 1'b0;
            rom_data  <= 32'd0;
            rom_abort <= 1'b0;
            ram_rdata <= 32'd0;
            ram_abort <= 1'b0;
            mem_cen   <= 1'b1;
            mem_wen   <= 1'b1;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            cpu_en    <= cpu_en_nxt;
            rom_data  <= rom_data_nxt;
            rom_abort <= rom_abort_nxt;
            ram_rdata <= ram_rdata_nxt;
            ram_abort <= ram_abort_nxt;
            mem_cen   <= mem_cen_nxt;
            mem_wen   <= mem_wen_nxt;
            mem_be    <= mem_be_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_f_req   <= 1'b0;
            lat_f_addr  <= 32'd0;
            lat_d_req   <= 1'b0;
            lat_d_wen   <= 1'b1;
            lat_d_flag  <= 4'h0;
            lat_d_addr  <= 32'd0;
            lat_d_wdata <= 32'd0;
        end else if (state == S_IDLE) begin
            lat_f_req   <= rom_en;
            lat_f_addr  <= rom_addr;
            lat_d_req   <= ~ram_cen;
            lat_d_wen   <= ram_wen;
            lat_d_flag  <= ram_flag;
            lat_d_addr  <= ram_addr;
            lat_d_wdata <= ram_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_arb.sv
`default_nettype none
// tb_arm_mem_arb: directed self-checking bench with a behavioural SRAM model.
module tb_arm_mem_arb;

    localparam int MEM_AW = 14;
`ifdef ARB_FETCH_FIRST_EN
    localparam int D_SLOT = 2;
    localparam int F_SLOT = 1;
`else
    localparam int D_SLOT = 1;
    localparam int F_SLOT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_en;
    logic [31:0]       rom_addr;
    logic              ram_cen;
    logic              ram_wen;
    logic [3:0]        ram_flag;
    logic [31:0]       ram_addr;
    logic [31:0]       ram_wdata;
    logic              cpu_en;
    logic [31:0]       rom_data;
    logic              rom_abort;
    logic [31:0]       ram_rdata;
    logic              ram_abort;
    logic              mem_cen;
    logic              mem_wen;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int checks = 0;
    int errors = 0;
    int lat_n;
    logic              s_cen  [0:8];
    logic              s_wen  [0:8];
    logic [3:0]        s_be   [0:8];
    logic [MEM_AW-1:0] s_addr [0:8];

    logic [31:0] sram [0:(1<<MEM_AW)-1];

    arm_mem_arb #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst),
        .rom_en(rom_en), .rom_addr(rom_addr),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_flag(ram_flag),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_en(cpu_en), .rom_data(rom_data), .rom_abort(rom_abort),
        .ram_rdata(ram_rdata), .ram_abort(ram_abort),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic sync_idle();
        int n = 0;
        while (!cpu_en && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!cpu_en) begin
            errors++;
            $display("FAIL sync_idle cpu_en=%b expected 1", cpu_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_txn(input logic fe, input logic [31:0] fa, input logic dreq,
                          input logic dwen, input logic [3:0] flag,
                          input logic [31:0] da, input logic [31:0] wd);
        sync_idle();
        rom_en = fe; rom_addr = fa;
        ram_cen = ~dreq; ram_wen = dwen; ram_flag = flag; ram_addr = da; ram_wdata = wd;
        for (int i = 0; i <= 8; i++) begin
            s_cen[i] = 1'b1; s_wen[i] = 1'b1; s_be[i] = 4'h0; s_addr[i] = '0;
        end
        lat_n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            s_cen[i] = mem_cen; s_wen[i] = mem_wen; s_be[i] = mem_be; s_addr[i] = mem_addr;
            if (cpu_en) begin
                lat_n = i;
                break;
            end
        end
        checks++;
        if (lat_n == 0) begin
            errors++;
            $display("FAIL txn_timeout cpu_en never rose within 8 cycles");
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cpu_en, rom_abort, ram_abort, mem_cen, mem_wen, mem_be} !== 9'b000_11_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 000110000",
                     {cpu_en, rom_abort, ram_abort, mem_cen, mem_wen, mem_be});
        end
        checks++;
        if ({rom_data, ram_rdata, mem_wdata, 18'(mem_addr)} !== '0) begin
            errors++;
            $display("FAIL reset_data rom_data=%h ram_rdata=%h mem_wdata=%h mem_addr=%h expected 0",
                     rom_data, ram_rdata, mem_wdata, mem_addr);
        end
    endtask

    task automatic test_no_request();
        do_txn(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (lat_n !== 1) begin
            errors++;
            $display("FAIL idle_latency got %0d expected 1", lat_n);
        end
    endtask

    task automatic test_fetch_only();
        do_txn(1'b1, 32'h100, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (lat_n !== 3) begin
            errors++;
            $display("FAIL fetch_latency got %0d expected 3", lat_n);
        end
        checks++;
        if (s_cen[1] !== 1'b0 || s_addr[1] !== 14'h40 || s_cen[2] !== 1'b1) begin
            errors++;
            $display("FAIL fetch_issue cen1=%b addr1=%h cen2=%b expected 0 0040 1",
                     s_cen[1], s_addr[1], s_cen[2]);
        end
        checks++;
        if (rom_data !== 32'hE3A00001 || rom_abort !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data got %h/%b expected e3a00001/0", rom_data, rom_abort);
        end
    endtask

    task automatic test_fetch_data();
        do_txn(1'b1, 32'h104, 1'b1, 1'b1, 4'hF, 32'h2000, 32'h0);
        checks++;
        if (lat_n !== 4) begin
            errors++;
            $display("FAIL both_latency got %0d expected 4", lat_n);
        end
        checks++;
        if (s_cen[D_SLOT] !== 1'b0 || s_addr[D_SLOT] !== 14'h800 || s_wen[D_SLOT] !== 1'b1) begin
            errors++;
            $display("FAIL both_data_slot cen=%b addr=%h wen=%b expected 0 0800 1",
                     s_cen[D_SLOT], s_addr[D_SLOT], s_wen[D_SLOT]);
        end
        checks++;
        if (s_cen[F_SLOT] !== 1'b0 || s_addr[F_SLOT] !== 14'h41 || s_cen[3] !== 1'b1) begin
            errors++;
            $display("FAIL both_fetch_slot cen=%b addr=%h cen3=%b expected 0 0041 1",
                     s_cen[F_SLOT], s_addr[F_SLOT], s_cen[3]);
        end
        checks++;
        if (ram_rdata !== 32'hDEADBEEF || rom_data !== 32'hE1A00000) begin
            errors++;
            $display("FAIL both_results ram=%h rom=%h expected deadbeef e1a00000", ram_rdata, rom_data);
        end
    endtask

    task automatic test_write();
        do_txn(1'b0, 32'h0, 1'b1, 1'b0, 4'b0011, 32'h10, 32'h12345678);
        checks++;
        if (lat_n !== 3 || s_cen[1] !== 1'b0 || s_wen[1] !== 1'b0 || s_be[1] !== 4'b0011
            || s_addr[1] !== 14'h4) begin
            errors++;
            $display("FAIL write_issue lat=%0d cen=%b wen=%b be=%b addr=%h expected 3 0 0 0011 0004",
                     lat_n, s_cen[1], s_wen[1], s_be[1], s_addr[1]);
        end
        checks++;
        if (s_wen[2] !== 1'b1 || s_cen[2] !== 1'b1) begin
            errors++;
            $display("FAIL write_one_cycle wen2=%b cen2=%b expected 1 1", s_wen[2], s_cen[2]);
        end
        checks++;
        if (ram_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_keeps_rdata got %h expected deadbeef", ram_rdata);
        end
        do_txn(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h0);
        checks++;
        if (ram_rdata !== 32'hCAFE5678 || lat_n !== 3) begin
            errors++;
            $display("FAIL write_readback got %h lat=%0d expected cafe5678 3", ram_rdata, lat_n);
        end
    endtask

    task automatic test_abort();
        do_txn(1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h0004_0000, 32'h0);
        checks++;
        if (lat_n !== 4 || s_cen[D_SLOT] !== 1'b1 || s_cen[F_SLOT] !== 1'b0
            || s_addr[F_SLOT] !== 14'h40) begin
            errors++;
            $display("FAIL abort_slots lat=%0d dcen=%b fcen=%b faddr=%h expected 4 1 0 0040",
                     lat_n, s_cen[D_SLOT], s_cen[F_SLOT], s_addr[F_SLOT]);
        end
        checks++;
        if (ram_abort !== 1'b1 || ram_rdata !== 32'h0 || rom_data !== 32'hE3A00001
            || rom_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_data ram_abort=%b ram_rdata=%h rom=%h rom_abort=%b expected 1 0 e3a00001 0",
                     ram_abort, ram_rdata, rom_data, rom_abort);
        end
        do_txn(1'b1, 32'h104, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (ram_abort !== 1'b1 || rom_data !== 32'hE1A00000) begin
            errors++;
            $display("FAIL abort_hold ram_abort=%b rom=%h expected 1 e1a00000", ram_abort, rom_data);
        end
        do_txn(1'b1, 32'h0010_0000, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rom_abort !== 1'b1 || rom_data !== 32'h0 || s_cen[1] !== 1'b1 || lat_n !== 3) begin
            errors++;
            $display("FAIL rom_abort got abort=%b data=%h cen1=%b lat=%0d expected 1 0 1 3",
                     rom_abort, rom_data, s_cen[1], lat_n);
        end
        do_txn(1'b1, 32'h103, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        checks++;
        if (rom_abort !== 1'b0 || s_addr[1] !== 14'h40 || rom_data !== 32'hE3A00001) begin
            errors++;
            $display("FAIL unaligned_fetch abort=%b addr=%h data=%h expected 0 0040 e3a00001",
                     rom_abort, s_addr[1], rom_data);
        end
    endtask

    task automatic test_reset_midwrite();
        sync_idle();
        rom_en = 1'b0; ram_cen = 1'b0; ram_wen = 1'b0; ram_flag = 4'hF;
        ram_addr = 32'h20; ram_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        checks++;
        if (mem_cen !== 1'b0 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL midwrite_issue cen=%b wen=%b expected 0 0", mem_cen, mem_wen);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_be !== 4'h0 || cpu_en !== 1'b0
            || rom_data !== 32'h0 || ram_rdata !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midwrite_async cen=%b wen=%b be=%h cpu_en=%b rom=%h ram=%h wd=%h expected reset values",
                     mem_cen, mem_wen, mem_be, cpu_en, rom_data, ram_rdata, mem_wdata);
        end
        ram_cen = 1'b1; ram_wen = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        do_txn(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h0);
        checks++;
        if (ram_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL midwrite_not_committed got %h expected 0badf00d", ram_rdata);
        end
    endtask

    initial begin
        sram[14'h4]   = 32'hCAFEBABE;
        sram[14'h8]   = 32'h0BADF00D;
        sram[14'h40]  = 32'hE3A00001;
        sram[14'h41]  = 32'hE1A00000;
        sram[14'h800] = 32'hDEADBEEF;
        mem_rdata = 32'h0;
        rst = 1'b0;
        rom_en = 1'b0; rom_addr = 32'h0;
        ram_cen = 1'b1; ram_wen = 1'b1; ram_flag = 4'h0; ram_addr = 32'h0; ram_wdata = 32'h0;
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        test_no_request();
        test_fetch_only();
        test_fetch_data();
        test_write();
        test_abort();
        test_reset_midwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
